// File: rtl/load_store_unit_pkg.sv
// Shared encodings and default widths for the CPU memory-access stage,
// reused by the CPU core and the data memory.
package load_store_unit_pkg;

    localparam int LSU_ADDR_W = 12;
    localparam int LSU_DATA_W = 20;

    localparam logic [LSU_ADDR_W-1:0] LSU_STACK_TOP   = 12'hFFF;
    localparam logic [LSU_ADDR_W-1:0] LSU_STACK_LIMIT = 12'hF00;

    typedef enum logic [1:0] {
        OP_LD   = 2'd0,
        OP_ST   = 2'd1,
        OP_PUSH = 2'd2,
        OP_POP  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/load_store_unit_stack_pointer.sv
// Stack pointer register: points at the next free slot, grows downwards,
// and reports full/empty against the configured stack window.
module stack_pointer #(
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] STACK_TOP   = 12'hFFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 12'hF00
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dec_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] sp_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;

    always_comb begin
        sp_d = sp_q;
        if (dec_i) begin
            sp_d = sp_q - ADDR_W'(1);
        end else if (inc_i) begin
            sp_d = sp_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sp_q <= STACK_TOP;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Full means the slot below STACK_LIMIT would be written next.
    assign full_o  = (sp_q == STACK_LIMIT - ADDR_W'(1));
    assign empty_o = (sp_q == STACK_TOP);
    assign sp_o    = sp_q;

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one LD/ST/PUSH/POP at a time, drives the data
// memory for exactly one cycle, and returns a registered response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int                ADDR_W      = LSU_ADDR_W,
    parameter int                DATA_W      = LSU_DATA_W,
    parameter logic [ADDR_W-1:0] STACK_TOP   = LSU_STACK_TOP,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = LSU_STACK_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_load_en,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output state_t            dbg_state_o
);

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
    // a response on a rising edge with rsp_valid && rsp_ready; valid never waits
    // on ready, and req_* are only sampled while the unit is IDLE.

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              error_q, error_d;
    logic              sp_dec, sp_inc, sp_full, sp_empty;

    stack_pointer #(
        .ADDR_W      (ADDR_W),
        .STACK_TOP   (STACK_TOP),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_stack_pointer (
        .clk_i   (clock),
        .rst_i   (reset),
        .dec_i   (sp_dec),
        .inc_i   (sp_inc),
        .sp_o    (sp),
        .full_o  (sp_full),
        .empty_o (sp_empty)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        sp_dec       = 1'b0;
        sp_inc       = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        mem_load_en  = 1'b0;
        mem_write_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = op_t'(req_op);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    // Stack faults are answered without touching memory.
                    if ((op_t'(req_op) == OP_PUSH && sp_full) ||
                        (op_t'(req_op) == OP_POP && sp_empty)) begin
                        error_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        error_d = 1'b0;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                case (op_q)
                    OP_LD: begin
                        mem_address = addr_q;
                        mem_load_en = 1'b1;
                        rdata_d     = mem_rdata;
                    end
                    OP_ST: begin
                        mem_address  = addr_q;
                        mem_wdata    = wdata_q;
                        mem_write_en = 1'b1;
                    end
                    OP_PUSH: begin
                        mem_address  = sp;
                        mem_wdata    = wdata_q;
                        mem_write_en = 1'b1;
                        sp_dec       = 1'b1;
                    end
                    OP_POP: begin
                        mem_address = sp + ADDR_W'(1);
                        mem_load_en = 1'b1;
                        rdata_d     = mem_rdata;
                        sp_inc      = 1'b1;
                    end
                    default: ;
                endcase
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE) && !reset;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_error   = error_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a behavioural data memory, a stack/memory
// reference model, and one task per scenario.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam logic [11:0] TOP   = 12'hFFF;
    localparam logic [11:0] LIMIT = 12'hF00;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [11:0] req_addr = '0;
    logic [19:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [19:0] rsp_rdata;
    logic        rsp_error;
    logic [11:0] sp;
    logic [11:0] mem_address;
    logic [19:0] mem_wdata;
    logic        mem_load_en;
    logic        mem_write_en;
    logic [19:0] mem_rdata;
    state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .sp           (sp),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_load_en  (mem_load_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata),
        .dbg_state_o  (dbg_state)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural 4096 x 20 data memory and access monitor
    logic [19:0] mem [0:4095];
    int          wr_cnt = 0;
    int          ld_cnt = 0;
    logic [11:0] wr_addr_last = '0;
    logic [19:0] wr_data_last = '0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
    end

    assign mem_rdata = mem_load_en ? mem[mem_address] : 20'h0;

    always @(posedge clock) begin
        if (mem_write_en) begin
            mem[mem_address] <= mem_wdata;
            wr_cnt           <= wr_cnt + 1;
            wr_addr_last     <= mem_address;
            wr_data_last     <= mem_wdata;
        end
        if (mem_load_en) ld_cnt <= ld_cnt + 1;
    end

    // Reference model: sparse memory image plus the stack pointer
    logic [19:0] m_mem [int];
    int          m_sp = int'(TOP);
    logic [19:0] exp_q [$];

    function automatic logic [19:0] mem_rd(input int a);
        return m_mem.exists(a) ? m_mem[a] : 20'h0;
    endfunction

    task automatic model_op(input logic [1:0] op, input logic [11:0] addr, input logic [19:0] wd,
                            output logic e_err, output int e_wr, output int e_ld, output logic [11:0] e_wa);
        logic [19:0] rd;
        rd = '0; e_err = 1'b0; e_wr = 0; e_ld = 0; e_wa = '0;
        case (op)
            2'd0: begin rd = mem_rd(int'(addr)); e_ld = 1; end
            2'd1: begin m_mem[int'(addr)] = wd; e_wr = 1; e_wa = addr; end
            2'd2: begin
                if (m_sp == int'(LIMIT) - 1) e_err = 1'b1;
                else begin
                    m_mem[m_sp] = wd; e_wr = 1; e_wa = 12'(m_sp);
                    m_sp = (m_sp + 4095) % 4096;
                end
            end
            default: begin
                if (m_sp == int'(TOP)) e_err = 1'b1;
                else begin
                    m_sp = (m_sp + 1) % 4096;
                    rd = mem_rd(m_sp); e_ld = 1;
                end
            end
        endcase
        exp_q.push_back(rd);
    endtask

    // Drivers (called at a falling edge, return at a falling edge in IDLE)
    task automatic apply_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        m_sp = int'(TOP);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [11:0] addr, input logic [19:0] wd,
                          output logic [19:0] rd, output logic er, output int lat,
                          output int wr_d, output int ld_d, output logic [11:0] wa, output logic [19:0] wdo);
        int wr0, ld0, n;
        wr0 = wr_cnt; ld0 = ld_cnt; n = 0;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        req_valid = 1'b0;
        req_op = 2'($urandom); req_addr = 12'($urandom); req_wdata = 20'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(negedge clock); lat++; end
        rd = rsp_rdata; er = rsp_error;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        wr_d = wr_cnt - wr0; ld_d = ld_cnt - ld0; wa = wr_addr_last; wdo = wr_data_last;
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 20'h0 || rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got v=%b d=%h e=%b want 0/0/0", rsp_valid, rsp_rdata, rsp_error); end
        n_checks++; if (mem_load_en !== 1'b0 || mem_write_en !== 1'b0 || mem_address !== 12'h0 || mem_wdata !== 20'h0) begin n_fail++; $display("FAIL reset_mem: got le=%b we=%b a=%h d=%h want all 0", mem_load_en, mem_write_en, mem_address, mem_wdata); end
        n_checks++; if (sp !== TOP || dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_sp_state: got sp=%h st=%0d want fff/IDLE", sp, dbg_state); end
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_st_ld();
        logic [19:0] rd, wdo, exp_rd; logic er, e_err; int lat, wr_d, ld_d, e_wr, e_ld; logic [11:0] wa, e_wa;
        model_op(2'd1, 12'h010, 20'hABCDE, e_err, e_wr, e_ld, e_wa);
        run_op(2'd1, 12'h010, 20'hABCDE, rd, er, lat, wr_d, ld_d, wa, wdo);
        exp_rd = exp_q.pop_front();
        n_checks++; if (wr_d != 1 || wa !== 12'h010 || wdo !== 20'hABCDE) begin n_fail++; $display("FAIL st_write: got n=%0d a=%h d=%h want 1/010/abcde", wr_d, wa, wdo); end
        n_checks++; if (rd !== exp_rd || er !== 1'b0) begin n_fail++; $display("FAIL st_rsp: got d=%h e=%b want %h/0", rd, er, exp_rd); end
        model_op(2'd0, 12'h010, 20'h0, e_err, e_wr, e_ld, e_wa);
        run_op(2'd0, 12'h010, 20'h0, rd, er, lat, wr_d, ld_d, wa, wdo);
        exp_rd = exp_q.pop_front();
        n_checks++; if (rd !== 20'hABCDE || rd !== exp_rd || er !== 1'b0) begin n_fail++; $display("FAIL ld_rsp: got d=%h e=%b want abcde/0", rd, er); end
        n_checks++; if (lat != 2 || ld_d != 1 || wr_d != 0) begin n_fail++; $display("FAIL ld_timing: got lat=%0d loads=%0d writes=%0d want 2/1/0", lat, ld_d, wr_d); end
    endtask

    task automatic test_stack_order();
        logic [19:0] rd, wdo, exp_rd; logic er, e_err; int lat, wr_d, ld_d, e_wr, e_ld; logic [11:0] wa, e_wa;
        logic [19:0] vals [4];
        logic [1:0]  ops [4];
        vals = '{20'h11111, 20'h22222, 20'h0, 20'h0};
        ops  = '{2'd2, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 4; i++) begin
            model_op(ops[i], 12'h0, vals[i], e_err, e_wr, e_ld, e_wa);
            run_op(ops[i], 12'h0, vals[i], rd, er, lat, wr_d, ld_d, wa, wdo);
            exp_rd = exp_q.pop_front();
            n_checks++; if (rd !== exp_rd || er !== e_err || lat != 2) begin n_fail++; $display("FAIL stack_rsp[%0d]: got d=%h e=%b lat=%0d want %h/%b/2", i, rd, er, lat, exp_rd, e_err); end
            n_checks++; if (wr_d != e_wr || (e_wr == 1 && (wa !== e_wa || wdo !== vals[i]))) begin n_fail++; $display("FAIL stack_write[%0d]: got n=%0d a=%h d=%h want %0d/%h/%h", i, wr_d, wa, wdo, e_wr, e_wa, vals[i]); end
            n_checks++; if (sp !== 12'(m_sp)) begin n_fail++; $display("FAIL stack_sp[%0d]: got %h want %h", i, sp, 12'(m_sp)); end
            if (i == 1) begin
                n_checks++; if (sp !== 12'hFFD) begin n_fail++; $display("FAIL stack_sp_after_push: got %h want ffd", sp); end
            end
        end
        n_checks++; if (sp !== TOP) begin n_fail++; $display("FAIL stack_sp_final: got %h want fff", sp); end
    endtask

    task automatic test_underflow();
        logic [19:0] rd, wdo; logic er; int lat, wr_d, ld_d; logic [11:0] wa;
        run_op(2'd3, 12'h0, 20'h0, rd, er, lat, wr_d, ld_d, wa, wdo);
        n_checks++; if (er !== 1'b1 || rd !== 20'h0) begin n_fail++; $display("FAIL underflow_rsp: got e=%b d=%h want 1/0", er, rd); end
        n_checks++; if (lat != 1 || wr_d != 0 || ld_d != 0) begin n_fail++; $display("FAIL underflow_access: got lat=%0d writes=%0d loads=%0d want 1/0/0", lat, wr_d, ld_d); end
        n_checks++; if (sp !== TOP) begin n_fail++; $display("FAIL underflow_sp: got %h want fff", sp); end
    endtask

    task automatic test_backpressure();
        logic [19:0] exp_rd; logic e_err; int e_wr, e_ld, wr0, n; logic [11:0] e_wa;
        model_op(2'd0, 12'h010, 20'h0, e_err, e_wr, e_ld, e_wa);
        exp_rd = exp_q.pop_front();
        wr0 = wr_cnt; n = 0;
        req_valid = 1'b1; req_op = 2'd0; req_addr = 12'h010; rsp_ready = 1'b0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        req_op = 2'd1; req_addr = 12'h055; req_wdata = 20'($urandom);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL backpressure[%0d]: got v=%b d=%h rdy=%b want 1/%h/0", i, rsp_valid, rsp_rdata, req_ready, exp_rd);
            end
            @(negedge clock);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        n_checks++; if (wr_cnt != wr0 || rsp_valid !== 1'b0 || dbg_state !== S_IDLE) begin n_fail++; $display("FAIL backpressure_release: got writes=%0d v=%b st=%0d want 0/0/IDLE", wr_cnt - wr0, rsp_valid, dbg_state); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] d; int wr0;
        d = 20'($urandom); wr0 = wr_cnt;
        req_valid = 1'b1; req_op = 2'd1; req_addr = 12'h020; req_wdata = d; rsp_ready = 1'b1;
        repeat (30) @(negedge clock);
        req_valid = 1'b0; rsp_ready = 1'b0;
        m_mem[32'h020] = d;
        n_checks++; if (wr_cnt - wr0 != 30 / 3) begin n_fail++; $display("FAIL back_to_back_rate: got %0d writes in 30 cycles want 10", wr_cnt - wr0); end
        n_checks++; if (rsp_valid !== 1'b0 || dbg_state !== S_IDLE) begin n_fail++; $display("FAIL back_to_back_end: got v=%b st=%0d want 0/IDLE", rsp_valid, dbg_state); end
    endtask

    task automatic test_overflow();
        logic [19:0] rd, wdo, d; logic er, e_err; int lat, wr_d, ld_d, e_wr, e_ld, bad; logic [11:0] wa, e_wa;
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            d = 20'($urandom);
            model_op(2'd2, 12'h0, d, e_err, e_wr, e_ld, e_wa);
            run_op(2'd2, 12'h0, d, rd, er, lat, wr_d, ld_d, wa, wdo);
            void'(exp_q.pop_front());
            if (er !== 1'b0 || wr_d != 1 || wa !== e_wa || wdo !== d) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL overflow_fill: got %0d bad pushes want 0", bad); end
        n_checks++; if (sp !== LIMIT) begin n_fail++; $display("FAIL overflow_sp_fill: got %h want f00", sp); end
        d = 20'($urandom);
        model_op(2'd2, 12'h0, d, e_err, e_wr, e_ld, e_wa);
        run_op(2'd2, 12'h0, d, rd, er, lat, wr_d, ld_d, wa, wdo);
        void'(exp_q.pop_front());
        n_checks++; if (er !== 1'b0 || wr_d != 1 || wa !== 12'hF00 || wdo !== d || sp !== 12'hEFF) begin n_fail++; $display("FAIL overflow_last_push: got e=%b n=%0d a=%h sp=%h want 0/1/f00/eff", er, wr_d, wa, sp); end
        model_op(2'd2, 12'h0, d, e_err, e_wr, e_ld, e_wa);
        run_op(2'd2, 12'h0, d, rd, er, lat, wr_d, ld_d, wa, wdo);
        void'(exp_q.pop_front());
        n_checks++; if (er !== 1'b1 || e_err !== 1'b1 || rd !== 20'h0 || wr_d != 0 || lat != 1 || sp !== 12'hEFF) begin n_fail++; $display("FAIL overflow_error: got e=%b d=%h n=%0d lat=%0d sp=%h want 1/0/0/1/eff", er, rd, wr_d, lat, sp); end
        apply_reset();
    endtask

    task automatic test_reset_mid_op();
        logic [19:0] d, rd, wdo; logic er; int lat, wr_d, ld_d, wr0, n; logic [11:0] wa;
        d = 20'($urandom); wr0 = wr_cnt; n = 0;
        req_valid = 1'b1; req_op = 2'd2; req_wdata = d;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        req_valid = 1'b0;
        n_checks++; if (mem_write_en !== 1'b1 || mem_address !== TOP || mem_wdata !== d) begin n_fail++; $display("FAIL midreset_access: got we=%b a=%h d=%h want 1/fff/%h", mem_write_en, mem_address, mem_wdata, d); end
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (dbg_state !== S_IDLE || sp !== TOP || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got st=%0d sp=%h v=%b want IDLE/fff/0", dbg_state, sp, rsp_valid); end
        n_checks++; if (mem_load_en !== 1'b0 || mem_write_en !== 1'b0 || mem_address !== 12'h0 || mem_wdata !== 20'h0) begin n_fail++; $display("FAIL midreset_mem: got le=%b we=%b a=%h d=%h want all 0", mem_load_en, mem_write_en, mem_address, mem_wdata); end
        n_checks++; if (wr_cnt - wr0 != 1 || wr_addr_last !== TOP || wr_data_last !== d) begin n_fail++; $display("FAIL midreset_commit: got n=%0d a=%h d=%h want 1/fff/%h", wr_cnt - wr0, wr_addr_last, wr_data_last, d); end
        reset = 1'b0;
        @(negedge clock);
        m_mem[int'(TOP)] = d; m_sp = int'(TOP);
        run_op(2'd0, TOP, 20'h0, rd, er, lat, wr_d, ld_d, wa, wdo);
        n_checks++; if (rd !== d || er !== 1'b0) begin n_fail++; $display("FAIL midreset_readback: got d=%h e=%b want %h/0", rd, er, d); end
    endtask

    task automatic test_random();
        logic [19:0] rd, wdo, exp_rd, d; logic er, e_err; int lat, wr_d, ld_d, e_wr, e_ld; logic [11:0] wa, e_wa, a;
        logic [1:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 1) == 1 ? 12'hFC0 : 12'h000) + 12'($urandom_range(0, 63));
            d  = 20'($urandom);
            model_op(op, a, d, e_err, e_wr, e_ld, e_wa);
            run_op(op, a, d, rd, er, lat, wr_d, ld_d, wa, wdo);
            exp_rd = exp_q.pop_front();
            n_checks++; if (rd !== exp_rd || er !== e_err) begin n_fail++; $display("FAIL rand_rsp[%0d] op=%0d a=%h: got d=%h e=%b want %h/%b", i, op, a, rd, er, exp_rd, e_err); end
            n_checks++; if (lat != (e_err ? 1 : 2)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, e_err ? 1 : 2); end
            n_checks++; if (wr_d != e_wr || ld_d != e_ld) begin n_fail++; $display("FAIL rand_access[%0d]: got writes=%0d loads=%0d want %0d/%0d", i, wr_d, ld_d, e_wr, e_ld); end
            if (e_wr == 1) begin
                n_checks++; if (wa !== e_wa || wdo !== d) begin n_fail++; $display("FAIL rand_write[%0d]: got a=%h d=%h want %h/%h", i, wa, wdo, e_wa, d); end
            end
            n_checks++; if (sp !== 12'(m_sp)) begin n_fail++; $display("FAIL rand_sp[%0d]: got %h want %h", i, sp, 12'(m_sp)); end
        end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_st_ld();
        test_stack_order();
        test_underflow();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
